// File: rtl/div_unit_if.sv
// Request/response bundle for the RV64M divide unit.
// The master side is execute control; the slave side is div_unit.
interface div_unit_if #(
   parameter int XLEN = 64
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] srca;
   logic [XLEN-1:0] srcb;
   logic [1:0]      op;
   logic            is_word;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output flush, in_valid, srca, srcb,
      output op, is_word, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  flush, in_valid, srca, srcb,
      input  op, is_word, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and W forms.
// Define DIV_FAST_PATH_EN for single-cycle trivial cases.
module div_unit #(
   parameter int XLEN = 64
) (
   input logic       clk,
   input logic       reset,
   div_unit_if.slave bus
);
   localparam int HX = XLEN / 2;
   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [XLEN-1:0] MIN_D =
      {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W =
      {{HX{1'b0}}, 1'b1, {(HX-1){1'b0}}};

   logic [1:0]      r_state;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_div;
   logic [XLEN-1:0] r_result;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_is_rem;
   logic            r_is_word;

   logic            w_signed;
   logic            w_is_rem;
   logic [XLEN-1:0] w_a_ext;
   logic [XLEN-1:0] w_b_ext;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_b_zero;
   logic            w_neg_q;
   logic [XLEN-1:0] w_dvd_init;
   logic [CW-1:0]   w_count_init;

   logic [XLEN:0]   w_shift;
   logic [XLEN:0]   w_diff;
   logic            w_qbit;
   logic [XLEN-1:0] w_rem_nxt;
   logic [XLEN-1:0] w_quo_nxt;

   logic            w_fast;
   logic [XLEN-1:0] w_fast_res;

   // Apply the sign fix-up, then narrow and sign-extend W results.
   function automatic logic [XLEN-1:0] f_final(
      input logic [XLEN-1:0] q,
      input logic [XLEN-1:0] r,
      input logic            nq,
      input logic            nr,
      input logic            rem,
      input logic            word
   );
      logic [XLEN-1:0] v;
      logic            n;
      v = rem ? r : q;
      n = rem ? nr : nq;
      if (n) begin
         v = {XLEN{1'b0}} - v;
      end
      if (word) begin
         v = {{HX{v[HX-1]}}, v[HX-1:0]};
      end
      return v;
   endfunction

   assign w_signed = ~bus.op[0];
   assign w_is_rem = bus.op[1];

   always_comb begin
      w_a_ext = bus.srca;
      w_b_ext = bus.srcb;
      if (bus.is_word) begin
         w_a_ext = {{HX{w_signed & bus.srca[HX-1]}},
                    bus.srca[HX-1:0]};
         w_b_ext = {{HX{w_signed & bus.srcb[HX-1]}},
                    bus.srcb[HX-1:0]};
      end
   end

   assign w_a_neg  = w_signed & w_a_ext[XLEN-1];
   assign w_b_neg  = w_signed & w_b_ext[XLEN-1];
   assign w_a_mag  = w_a_neg ? ({XLEN{1'b0}} - w_a_ext)
                             : w_a_ext;
   assign w_b_mag  = w_b_neg ? ({XLEN{1'b0}} - w_b_ext)
                             : w_b_ext;
   assign w_b_zero = (w_b_ext == {XLEN{1'b0}});
   // A zero divisor must leave the all-ones quotient unsigned.
   assign w_neg_q  = (w_a_neg ^ w_b_neg) & ~w_b_zero;

   // W dividends sit in the top half so the MSB is shifted out first.
   assign w_dvd_init = bus.is_word
                     ? {w_a_mag[HX-1:0], {HX{1'b0}}}
                     : w_a_mag;
   assign w_count_init = bus.is_word ? CW'(HX) : CW'(XLEN);

   assign w_shift   = {r_rem, r_quo[XLEN-1]};
   assign w_diff    = w_shift - {1'b0, r_div};
   assign w_qbit    = ~w_diff[XLEN];
   assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0]
                             : w_shift[XLEN-1:0];
   assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};

`ifdef DIV_FAST_PATH_EN
   logic            w_ovf;
   logic [XLEN-1:0] w_min;
   logic [XLEN-1:0] w_fq;
   logic [XLEN-1:0] w_fr;

   assign w_min  = bus.is_word ? MIN_W : MIN_D;
   assign w_ovf  = w_signed & (&w_b_ext) & w_a_neg
                 & (w_a_mag == w_min);
   assign w_fast = w_b_zero | w_ovf | (w_a_mag < w_b_mag);
   assign w_fq   = w_b_zero ? {XLEN{1'b1}}
                 : (w_ovf ? w_a_mag : {XLEN{1'b0}});
   assign w_fr   = w_ovf ? {XLEN{1'b0}} : w_a_mag;
   assign w_fast_res = f_final(w_fq, w_fr, w_neg_q, w_a_neg,
                               w_is_rem, bus.is_word);
`else
   logic [2*XLEN-1:0] w_unused;

   assign w_unused   = {MIN_D, MIN_W};
   assign w_fast     = 1'b0;
   assign w_fast_res = {XLEN{1'b0}};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_div     <= '0;
         r_result  <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_is_rem  <= 1'b0;
         r_is_word <= 1'b0;
      end else if (bus.flush) begin
         r_state <= S_IDLE;
      end else begin
         unique case (1'b1)
            (r_state == S_IDLE): begin
               if (bus.in_valid) begin
                  r_rem     <= '0;
                  r_quo     <= w_dvd_init;
                  r_div     <= w_b_mag;
                  r_count   <= w_count_init;
                  r_neg_q   <= w_neg_q;
                  r_neg_r   <= w_a_neg;
                  r_is_rem  <= w_is_rem;
                  r_is_word <= bus.is_word;
                  if (w_fast) begin
                     r_result <= w_fast_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_BUSY;
                  end
               end
            end
            (r_state == S_BUSY): begin
               r_rem   <= w_rem_nxt;
               r_quo   <= w_quo_nxt;
               r_count <= r_count - 1'b1;
               if (r_count == CW'(1)) begin
                  r_state  <= S_DONE;
                  r_result <= f_final(w_quo_nxt, w_rem_nxt,
                                      r_neg_q, r_neg_r,
                                      r_is_rem, r_is_word);
               end
            end
            (r_state == S_DONE): begin
               if (bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE) & ~bus.flush;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.result    = r_result;
   assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed spec cases plus
// random operands against an arithmetic reference model.
module tb_div_unit;
   localparam int XLEN = 64;

   typedef struct {
      logic [63:0] res;
      int          acc;
      int          lat;
      int          id;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   bit   hold = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   nid = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_unit_if #(.XLEN(XLEN)) bus ();

   div_unit #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [63:0] ref_res(
      input logic [63:0] a,
      input logic [63:0] b,
      input logic [1:0]  op,
      input bit          w
   );
      logic [31:0] ua, ub, q32, r32, v32;
      logic [63:0] q, r;
      int          sa, sbv;
      longint      la, lb;
      if (w) begin
         ua = a[31:0];
         ub = b[31:0];
         sa = ua;
         sbv = ub;
         if (ub == 0) begin
            q32 = '1;
            r32 = ua;
         end else if (!op[0] && ua == 32'h8000_0000
                      && ub == 32'hFFFF_FFFF) begin
            q32 = ua;
            r32 = 0;
         end else if (!op[0]) begin
            q32 = sa / sbv;
            r32 = sa % sbv;
         end else begin
            q32 = ua / ub;
            r32 = ua % ub;
         end
         v32 = op[1] ? r32 : q32;
         return {{32{v32[31]}}, v32};
      end
      la = a;
      lb = b;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (!op[0] && a == 64'h8000_0000_0000_0000
                   && b == '1) begin
         q = a;
         r = 0;
      end else if (!op[0]) begin
         q = la / lb;
         r = la % lb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic int ref_lat(
      input logic [63:0] a,
      input logic [63:0] b,
      input logic [1:0]  op,
      input bit          w
   );
      logic [63:0] ea, eb, ma, mb;
      bit          sg, fast, ovf;
      int          n;
      sg = !op[0];
      n = w ? 32 : 64;
      ea = a;
      eb = b;
      if (w) begin
         ea = sg ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]};
         eb = sg ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]};
      end
      ma = (sg && ea[63]) ? -ea : ea;
      mb = (sg && eb[63]) ? -eb : eb;
      ovf = sg && eb == '1 && (w ? ea == 64'hFFFF_FFFF_8000_0000
                                 : ea == 64'h8000_0000_0000_0000);
      fast = (eb == 0) || ovf || (ma < mb);
`ifdef DIV_FAST_PATH_EN
      return fast ? 1 : n + 1;
`else
      return fast ? n + 1 : n + 1;
`endif
   endfunction

   task automatic issue(
      input logic [63:0] a,
      input logic [63:0] b,
      input logic [1:0]  op,
      input bit          w,
      input logic [63:0] exp_res
   );
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.srca = a;
      bus.srcb = b;
      bus.op = op;
      bus.is_word = w;
      forever begin
         #3;
         if (bus.in_ready) begin
            e.res = exp_res;
            e.acc = cyc + 1;
            e.lat = ref_lat(a, b, op, w);
            e.id = nid;
            nid++;
            sb.push_back(e);
            break;
         end
         if (n++ > 300) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got=0 exp=1");
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic issue_m(
      input logic [63:0] a,
      input logic [63:0] b,
      input logic [1:0]  op,
      input bit          w
   );
      issue(a, b, op, w, ref_res(a, b, op, w));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got=%0d exp=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : monitor
      bit seen;
      int lat;
      exp_t e;
      seen = 0;
      forever begin
         @(negedge clk);
         #3;
         if (reset === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out got=1 exp=0");
            end else begin
               if (!seen) begin
                  seen = 1;
                  lat = cyc + 1 - sb[0].acc;
                  chk("latency", 64'(lat), 64'(sb[0].lat));
               end
               if (bus.out_ready) begin
                  e = sb.pop_front();
                  checks++;
                  if (bus.result !== e.res) begin
                     errors++;
                     $display("FAIL result id=%0d got=%h exp=%h",
                              e.id, bus.result, e.res);
                  end
                  seen = 0;
               end
            end
         end else begin
            seen = 0;
         end
      end
   end

   initial begin
      logic [63:0] da[12], db[12], dr[12];
      logic [1:0]  dop[12];
      bit          dw[12];
      logic [63:0] a, b, hr;
      logic [1:0]  op;
      bit          w, held_ok;
      int          n;

      da  = '{100, 100, -7, -7, 5, 5,
              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h1_8000_0000, 64'hFFFF_FFFF, 5, 64'h8000_0001};
      db  = '{7, 7, 2, 2, 0, 0, '1, '1, '1, 1, 0, 0};
      dop = '{1, 3, 2, 0, 0, 2, 0, 2, 0, 1, 1, 3};
      dw  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
      dr  = '{14, 2, '1, 64'hFFFF_FFFF_FFFF_FFFD, '1, 5,
              64'h8000_0000_0000_0000, 0,
              64'hFFFF_FFFF_8000_0000, '1, '1,
              64'hFFFF_FFFF_8000_0001};

      reset = 1'b0;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.srca = '0;
      bus.srcb = '0;
      bus.op = '0;
      bus.is_word = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      chk("reset_out_valid", 64'(bus.out_valid), 0);
      chk("reset_result", bus.result, 0);
      chk("reset_busy", 64'(bus.busy), 0);
      @(negedge clk);
      reset = 1'b1;
      #3;
      chk("in_ready_after_reset", 64'(bus.in_ready), 1);

      for (int i = 0; i < 12; i++) begin
         issue(da[i], db[i], dop[i], dw[i], dr[i]);
         drain();
      end

      for (int i = 0; i < 60; i++) begin
         w = $urandom_range(0, 1);
         op = 2'($urandom_range(0, 3));
         a = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0)
            a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
         else if ($urandom_range(0, 5) == 0)
            a = -64'($urandom_range(1, 100));
         case ($urandom_range(0, 5))
            0: b = 0;
            1: b = '1;
            2: b = 64'($urandom_range(1, 15));
            3: b = {$urandom, $urandom};
            4: b = {32'h0, $urandom};
            default: b = a >> $urandom_range(0, 8);
         endcase
         issue_m(a, b, op, w);
         drain();
      end

      hold = 1'b1;
      issue(1000, 3, 1, 0, 333);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk("bp_valid_seen", 64'(bus.out_valid), 1);
      hr = bus.result;
      held_ok = 1;
      repeat (10) begin
         @(negedge clk);
         #3;
         if (!(bus.out_valid && !bus.in_ready && bus.result === hr))
            held_ok = 0;
      end
      chk("bp_held", 64'(held_ok), 1);
      chk("bp_result", hr, 333);
      hold = 1'b0;
      drain();

      issue_m({$urandom, $urandom}, 64'h1234_5678, 1, 0);
      repeat (19) @(negedge clk);
      #3;
      chk("busy_before_flush", 64'(bus.busy), 1);
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      #3;
      chk("flush_busy", 64'(bus.busy), 0);
      chk("flush_out_valid", 64'(bus.out_valid), 0);
      void'(sb.pop_back());
      issue_m(-64'd1000, 64'd7, 2, 0);
      drain();

      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.flush = 1'b1;
      #3;
      chk("flush_blocks_ready", 64'(bus.in_ready), 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      #3;
      chk("flush_no_accept", 64'(bus.busy), 0);

      issue_m(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_0000_0003,
              1, 0);
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midop_reset_busy", 64'(bus.busy), 0);
      chk("midop_reset_result", bus.result, 0);
      void'(sb.pop_back());
      @(negedge clk);
      reset = 1'b1;
      #3;
      chk("midop_reset_ready", 64'(bus.in_ready), 1);
      issue_m(64'hFFFF_FFFF_FFFF_FF00, 64'h10, 0, 1);
      drain();

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
